// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control FSM with memory-ready waits, timeout and trap
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unlisted opcodes in DECODE trap with cause 01)
module mc_control_fsm #(
  parameter int         ALUOP_W     = 3,
  parameter int         MAX_WAIT    = 8,
  parameter logic [1:0] TRAP_PC_SEL = 2'b11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               branch,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               bne_sel,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               trap,
  output logic [1:0]         cause,
  output logic [4:0]         state
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_RTYPEEX = 5'd6,
    S_RTYPEWB = 5'd7,
    S_BEQEX   = 5'd8,
    S_BNEEX   = 5'd9,
    S_IMMEX   = 5'd10,
    S_IMMWB   = 5'd11,
    S_JEX     = 5'd12,
    S_TRAP    = 5'd13
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          mem_wait;
  logic          timeout;

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // A ready in the final allowed cycle beats the timeout.
  assign timeout  = mem_wait && !mem_ready && (wait_q == CW'(MAX_WAIT - 1));

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_RTYPE:                           state_d = S_RTYPEEX;
          OP_BEQ:                             state_d = S_BEQEX;
          OP_BNE:                             state_d = S_BNEEX;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI:  state_d = S_IMMEX;
          OP_J:                               state_d = S_JEX;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_BNEEX:   state_d = S_FETCH;
      S_IMMEX:   state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_TRAP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
    // Counter only survives while stalled in the same memory state.
    if (mem_wait && !mem_ready && !timeout) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    pcwrite  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    bne_sel  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = '0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        pcwrite = mem_ready;
        irwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_W'(3'b010);
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        aluop   = ALUOP_W'(3'b001);
        bne_sel = (state_q == S_BNEEX);
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ORI:  aluop = ALUOP_W'(3'b100);
          OP_ANDI: aluop = ALUOP_W'(3'b101);
          OP_SLTI: aluop = ALUOP_W'(3'b111);
          default: aluop = ALUOP_W'(3'b000);
        endcase
      end
      S_IMMWB: regwrite = 1'b1;
      S_JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      S_TRAP: begin
        pcwrite = 1'b1;
        pcsrc   = TRAP_PC_SEL;
        trap    = 1'b1;
      end
      default: ;
    endcase
  end

  assign cause = cause_q;
  assign state = state_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control FSM for the MIPS datapath. It decodes the 6-bit opcode into per-state datapath controls and supports lw, sw, R-type, beq, bne, addi, ori, andi, slti and j. Unlike the fixed-latency decoder, it waits on a memory-ready handshake and bounds every wait with a timeout counter. It also raises a trap with a cause code. It sits between the instruction register opcode field and the multicycle datapath/ALU decoder.

## Interface
- ALUOP_W, 3: width of aluop; must be ≥3. Codes are zero-extended.
- MAX_WAIT, 8: consecutive not-ready cycles tolerated in a memory state before a timeout trap; must be ≥1.
- TRAP_PC_SEL, 2'b11: pcsrc value that selects the exception vector.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- op  in  6  opcode, instr[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst  out  1 each  datapath enables/selects
- bne_sel  out  1  branch on not-zero (pc enable = branch & (zero ^ bne_sel))
- alusrcb  out  2  ALU B select: 00 reg, 01 +4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  PC select: 00 ALU, 01 ALUOut, 10 jump, TRAP_PC_SEL vector
- aluop  out  ALUOP_W  000 add, 001 sub, 010 funct, 100 or, 101 and, 111 slt
- trap  out  1  one-cycle pulse in TRAP
- cause  out  2  registered; 01 illegal opcode, 10 memory timeout
- state  out  5  current state, for debug

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, BNEEX 9, IMMEX 10, IMMWB 11, JEX 12, TRAP 13. Codes 14–31 go to FETCH with all outputs 0.
- Outputs are combinational from state, op and mem_ready. Unlisted outputs are 0.
- FETCH: alusrcb=01. pcwrite=irwrite=mem_ready. Advance to DECODE on mem_ready.
- DECODE: alusrcb=11. Next state by op:
  - 100011/101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 000101 → BNEEX
  - 001000/001101/001100/001010 → IMMEX
  - 000010 → JEX
  - else illegal (see Configuration).
- MEMADR: alusrca=1, alusrcb=10. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Advance to MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1, held during the wait. Advance to FETCH on mem_ready.
- RTYPEEX: alusrca=1, aluop=010.
- RTYPEWB: regwrite=1, regdst=1.
- BEQEX/BNEEX: alusrca=1, branch=1, pcsrc=01, aluop=001. bne_sel=1 in BNEEX only.
- IMMEX: alusrca=1, alusrcb=10. aluop is 000 for addi, 100 for ori, 101 for andi, 111 for slti.
- IMMWB: regwrite=1.
- JEX: pcwrite=1, pcsrc=10.
- TRAP: pcwrite=1, pcsrc=TRAP_PC_SEL, trap=1. Next state FETCH.
- Wait counter, width $clog2(MAX_WAIT+1):
  - Increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - If mem_ready=0 while count==MAX_WAIT-1, next state is TRAP with cause←10. Memory enables are not qualified further.
  - If mem_ready=1 arrives in that same cycle, ready wins and no trap occurs.
- cause loads on entry to TRAP and holds until the next trap.

## Timing
- Reset: state=FETCH, counter=0, cause=00, trap=0. Outputs follow FETCH: alusrcb=01, pcwrite=irwrite=mem_ready.
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R-type and immediate ops 4; beq, bne and j 3; trap entry plus vector 3.
- Each not-ready cycle in a memory state adds exactly one cycle.
- Reset asserted mid-instruction returns the FSM to FETCH immediately; no write enable stays asserted.

## Configuration
- ILLEGAL_OP_TRAP_EN defined: an unlisted op in DECODE → TRAP with cause←01.
- Not defined: an unlisted op in DECODE → FETCH as a no-op with no writes; cause is unchanged. Timeout traps exist either way.

## Test plan
- lw (op=100011), mem_ready=1: state sequence 0,1,2,3,4,0. regwrite & memtoreg high only in state 4.
- sw with mem_ready low 3 cycles in MEMWR: memwrite high for 4 cycles, then FETCH. trap stays 0.
- beq, then bne, then andi (op=001100): aluop 001 with bne_sel=0, then 001 with bne_sel=1, then 101 in IMMEX. Total cycles 3+3+4.
- MAX_WAIT=8, mem_ready held 0 in FETCH: 8 stall cycles, then TRAP for one cycle with pcsrc=11 and trap=1, cause=10, then FETCH.
- op=111111 with ILLEGAL_OP_TRAP_EN: DECODE→TRAP, cause=01. Without the macro: DECODE→FETCH, cause unchanged.
- Reset asserted in MEMWR while memwrite=1: the next sampled state is FETCH and memwrite is 0.
